// File: rtl/seq_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_pattern_gen: shifts a pattern MSB-first for N repetitions with idle     |
// | gaps between them, and counts overlapping "101" on the line. Rev 1.0        |
// +----------------------------------------------------------------------------+
module seq_pattern_gen #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   reps,
  input  logic [3:0]         gap,
  input  logic               abort,
  output logic               x,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   reps_left_q, reps_left_d;
  logic [3:0]         gap_q, gap_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic               x_q, x_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [1:0]         hist_q, hist_d;
  logic [LEN_W-1:0]   len_m1;

  assign len_m1 = len - LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    last_idx_d  = last_idx_q;
    idx_d       = idx_q;
    reps_left_d = reps_left_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    x_d         = 1'b0;
    valid_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    hit_d       = hit_q;
    hist_d      = hist_q;

    case (state_q)
      ST_IDLE: begin
        // The done pulse cycle still belongs to the completing run.
        if (start && !done_q) begin
          hit_d  = '0;
          hist_d = 2'b00;
          if (len != '0 && reps != '0) begin
            pat_d       = pat;
            last_idx_d  = len_m1[IDX_W-1:0];
            idx_d       = len_m1[IDX_W-1:0];
            reps_left_d = reps;
            gap_d       = gap;
            state_d     = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          x_d     = pat_q[idx_q];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          hist_d  = {hist_q[0], x_d};
          if (x_d && hist_q == 2'b10 && hit_q != {CNT_W{1'b1}}) begin
            hit_d = hit_q + CNT_W'(1);
          end
          if (idx_q == '0) begin
            if (reps_left_q > CNT_W'(1)) begin
              reps_left_d = reps_left_q - CNT_W'(1);
              if (gap_q != 4'd0) begin
                gap_cnt_d = gap_q;
                state_d   = ST_GAP;
              end else begin
                idx_d = last_idx_q;
              end
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
          hist_d = {hist_q[0], 1'b0};
          if (gap_cnt_q <= 4'd1) begin
            idx_d   = last_idx_q;
            state_d = ST_SHIFT;
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end
        end
      end

      default: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      last_idx_q  <= '0;
      idx_q       <= '0;
      reps_left_q <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      x_q         <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= '0;
      hist_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      last_idx_q  <= last_idx_d;
      idx_q       <= idx_d;
      reps_left_q <= reps_left_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      x_q         <= x_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      hist_q      <= hist_d;
    end
  end

  assign x       = x_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign hit_cnt = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_pattern_gen: directed vectors against hand-derived waveforms.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_seq_pattern_gen;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   reps;
  logic [3:0]         gap;
  logic               abort;
  logic               x;
  logic               valid;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   hit_cnt;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  seq_pattern_gen #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pat     (pat),
    .len     (len),
    .reps    (reps),
    .gap     (gap),
    .abort   (abort),
    .x       (x),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic ex, input logic ev,
                     input logic eb, input logic ed);
    tick();
    chk({tag, ".x"}, 32'(x), 32'(ex));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  // Vectors are written MSB-first: bit n-1 is the first cycle after launch.
  task automatic stream(input string tag, input logic [31:0] xs, input logic [31:0] vs,
                        input logic [31:0] bs, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s.x[%0d]", tag, i), 32'(x), 32'(xs[n-1-i]));
      chk($sformatf("%s.valid[%0d]", tag, i), 32'(valid), 32'(vs[n-1-i]));
      chk($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'(bs[n-1-i]));
    end
  endtask

  task automatic launch(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                        input logic [CNT_W-1:0] r, input logic [3:0] g);
    pat   = p;
    len   = l;
    reps  = r;
    gap   = g;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input logic [CNT_W-1:0] exp_hit);
    cyc({tag, ".end"}, 1'b0, 1'b0, 1'b0, 1'b1);
    chk({tag, ".hit"}, 32'(hit_cnt), 32'(exp_hit));
    cyc({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int k;
    int busy_cycles;
    rst_n = 1'b0;
    start = 1'b0;
    pat   = '0;
    len   = '0;
    reps  = '0;
    gap   = '0;
    abort = 1'b0;
    #3;
    chk("rst.x", 32'(x), 32'd0);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.hit", 32'(hit_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 101 once: one hit
    launch(16'b101, 5'd3, 8'd1, 4'd0);
    chk("t1.lat_valid", 32'(valid), 32'd0);
    stream("t1", 32'b101, 32'b111, 32'b111, 3);
    finish_run("t1", 8'd1);

    // 10101: overlapping hits
    launch(16'b10101, 5'd5, 8'd1, 4'd0);
    stream("t2", 32'b10101, 32'b11111, 32'b11111, 5);
    finish_run("t2", 8'd2);

    // 10 x3 back-to-back: hits span repetition boundaries
    launch(16'b10, 5'd2, 8'd3, 4'd0);
    stream("t3", 32'b101010, 32'b111111, 32'b111111, 6);
    finish_run("t3", 8'd2);

    // 10 x3 with 2-cycle gaps: gap zeros break every match
    launch(16'b10, 5'd2, 8'd3, 4'd2);
    stream("t3g", 32'b1000100010, 32'b1100110011, 32'h3FF, 10);
    finish_run("t3g", 8'd0);

    // 101 x3, stray start mid-run, abort on the 5th bit
    launch(16'b101, 5'd3, 8'd3, 4'd0);
    cyc("t4.b1", 1'b1, 1'b1, 1'b1, 1'b0);
    pat   = 16'h0000;
    len   = 5'd2;
    reps  = 8'd1;
    start = 1'b1;
    cyc("t4.b2", 1'b0, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    cyc("t4.b3", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("t4.b4", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("t4.b5", 1'b0, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    cyc("t4.abort", 1'b0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    chk("t4.hit", 32'(hit_cnt), 32'd1);
    cyc("t4.after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4.hit_hold", 32'(hit_cnt), 32'd1);

    // len==0: immediate done, hit cleared, nothing sent
    launch(16'hFFFF, 5'd0, 8'd4, 4'd0);
    chk("t5.lat_valid", 32'(valid), 32'd0);
    finish_run("t5", 8'd0);

    // reps==0 behaves the same way
    launch(16'b101, 5'd3, 8'd0, 4'd0);
    chk("t5r.lat_valid", 32'(valid), 32'd0);
    finish_run("t5r", 8'd0);

    // Saturation: 0xAAAA x40 yields 319 matches, clamped at 255
    launch(16'hAAAA, 5'd16, 8'd40, 4'd0);
    k = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && k < 1000) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
      k++;
    end
    chk("sat.done", 32'(done), 32'd1);
    chk("sat.busy_len", 32'(busy_cycles), 32'd640);
    chk("sat.hit", 32'(hit_cnt), 32'd255);
    tick();

    // Asynchronous reset in the middle of a run
    launch(16'b10101, 5'd5, 8'd1, 4'd0);
    tick();
    tick();
    tick();
    chk("t6.pre_hit", 32'(hit_cnt), 32'd1);
    chk("t6.pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.x", 32'(x), 32'd0);
    chk("t6.valid", 32'(valid), 32'd0);
    chk("t6.busy", 32'(busy), 32'd0);
    chk("t6.hit", 32'(hit_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t6.post1", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t6.post2", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t6.post3", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial stimulus transmitter that drives the bit line of the 101 sequence detector. It loads a bit pattern of programmable length and shifts it out MSB-first, one bit per clock, for a programmable number of repetitions with optional idle gaps between them. It keeps its own overlapping count of "101" occurrences on the line, so a bench or the system can compare that count against the detector's z pulses.

Parameters:
MAX_LEN, 16, maximum pattern length in bits
CNT_W, 8, width of the repetition and hit counters
LEN_W, $clog2(MAX_LEN+1), width of the len input (derived, not overridden)

Ports:
clk  input  1  clock, all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to load and begin transmission; sampled only in IDLE
pat  input  MAX_LEN  pattern; bit len-1 is sent first
len  input  LEN_W  pattern length, 0..MAX_LEN
reps  input  CNT_W  number of pattern repetitions
gap  input  4  zero cycles inserted between repetitions
abort  input  1  stop the transmission immediately
x  output  1  serial bit to the detector (registered)
valid  output  1  high while x carries a pattern bit
busy  output  1  high in the SHIFT and GAP states
done  output  1  one-cycle pulse on normal completion
hit_cnt  output  CNT_W  overlapping "101" count for the current or last run

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; x, valid, busy, done = 0; hit_cnt = 0; bit history cleared. Reset overrides any in-progress run.
- States: IDLE, SHIFT, GAP, DONE. Encoding is free.
- IDLE: x=0, valid=0, busy=0.
  - start=1 with len!=0 and reps!=0: latch pat, len, reps, gap; clear hit_cnt and history; go to SHIFT.
  - start=1 with len==0 or reps==0: go to DONE. No bits are sent; hit_cnt is cleared.
- Latency: start is sampled at edge N. At edge N+1, x = pat[len-1] and valid=1.
- SHIFT: each edge presents the next bit and decrements the index. After the bit at index 0, with reps_left > 1:
  - reps_left decrements;
  - the next state is GAP if gap != 0, otherwise SHIFT with index = len-1 (back-to-back, no bubble).
  - With reps_left == 1, the next state is DONE.
- GAP: x=0, valid=0, busy=1, held for exactly gap cycles, then back to SHIFT at index len-1.
- DONE: one cycle with done=1, x=0, valid=0, busy=0; then IDLE.
- Run length: busy stays high for reps*len + (reps-1)*gap cycles.
- start while busy or in DONE: ignored; latched values are not disturbed.
- abort=1 in SHIFT or GAP: next edge goes to IDLE with x=0 and valid=0, and no done pulse. hit_cnt holds its value. abort in IDLE or DONE has no effect. If start and abort are both high in IDLE, start wins.
- Hit counting:
  - A 2-bit history holds the last two x values driven while busy. Gap zeros are included.
  - At the edge where x is loaded with 1 and the history is "10", hit_cnt increments. Overlap counts, and so does a match that spans a repetition boundary.
  - hit_cnt saturates at 2^CNT_W-1 and holds its value after the run until the next accepted start.
- Ordering: hit_cnt leads the detector's Moore z by one cycle.

Test Plan:
- pat=3'b101, len=3, reps=1, gap=0 → x=1,0,1 on cycles 1-3 with valid high; done on cycle 4; hit_cnt=1.
- pat=5'b10101, len=5, reps=1 → x=1,0,1,0,1; hit_cnt=2 (overlap); busy high for 5 cycles.
- pat=2'b10, len=2, reps=3, gap=0 → x=101010 contiguous; hit_cnt=2 (cross-rep match). Same with gap=2 → 10 00 10 00 10; hit_cnt=0; busy high for 10 cycles.
- pat=3'b101, reps=3, gap=0, abort asserted on the 5th bit → x=0 and busy=0 on the next cycle; no done; hit_cnt=1 held; a second start pulse during the run is ignored.
- len=0 (reps=4) → done pulses on the cycle after start; valid never rises; hit_cnt=0.
- rst_n dropped mid-SHIFT between clock edges → x, valid, busy and hit_cnt go to 0 immediately; after release the block stays in IDLE until start.
